// File: rtl/adder_pkg.sv
// Shared types and widths for the adder IP and its downstream stages.
package adder_pkg;

  localparam int ADDER_DW   = 32;
  localparam int DROP_CNT_W = 16;
  localparam int TAG_W      = 8;

  typedef struct packed {
    logic                carry;
    logic [ADDER_DW-1:0] sum;
  } adder_result_t;

endpackage

// File: rtl/adder_resbuf_fifo.sv
// Generic synchronous FIFO: pointers, storage and occupancy count with push/pop.
// The head entry is read straight from storage, so it holds still until popped.
module adder_resbuf_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_d_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o   = mem_q[rd_ptr_q];
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign count_d_o = count_d;

endmodule

// File: rtl/adder_result_buffer.sv
// Buffers adder results (no backpressure upstream) and re-issues them on a valid/ready stream.
// Define ADDER_RESBUF_TAG_EN to add an 8-bit sequence tag (out_tag) per accepted result.
module adder_result_buffer
  import adder_pkg::*;
#(
  parameter  int DATA_WIDTH = ADDER_DW,
  parameter  int DEPTH      = 8,
  parameter  int AF_THRESH  = 2,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_sum,
  input  logic                  in_carry,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_carry,
`ifdef ADDER_RESBUF_TAG_EN
  output logic [TAG_W-1:0]      out_tag,
`endif
  output logic                  almost_full,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0]      count
);

`ifdef ADDER_RESBUF_TAG_EN
  localparam int EW = TAG_W + 1 + DATA_WIDTH;
`else
  localparam int EW = 1 + DATA_WIDTH;
`endif
  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - AF_THRESH);

  logic             push, pop, drop, full, empty;
  logic [EW-1:0]    wdata, rdata;
  logic [CNT_W-1:0] count_d;

  logic                  out_valid_q, out_valid_d;
  logic                  af_q, af_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop  = out_valid_q && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

`ifdef ADDER_RESBUF_TAG_EN
  logic [TAG_W-1:0] tag_q, tag_d;

  assign tag_d   = push ? tag_q + 1'b1 : tag_q;
  assign wdata   = {tag_q, in_carry, in_sum};
  assign out_tag = rdata[EW-1 -: TAG_W];

  always_ff @(posedge clk) begin
    if (rst) tag_q <= '0;
    else     tag_q <= tag_d;
  end
`else
  assign wdata = {in_carry, in_sum};
`endif

  adder_resbuf_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (pop),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count),
    .count_d_o (count_d)
  );

  always_comb begin
    out_valid_d = (count_d != '0);
    af_d        = (count_d >= AF_LEVEL);
    overflow_d  = overflow_q || drop;
    drop_cnt_d  = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      af_q        <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      af_q        <= af_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sum     = rdata[DATA_WIDTH-1:0];
  assign out_carry   = rdata[DATA_WIDTH];
  assign almost_full = af_q;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;

  logic unused_empty;
  assign unused_empty = empty;

endmodule

// File: tb/tb_adder_result_buffer.sv
// Directed bench for adder_result_buffer (DEPTH=8, AF_THRESH=2); tag checks when ADDER_RESBUF_TAG_EN is defined.
module tb_adder_result_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_sum;
  logic        in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_carry;
`ifdef ADDER_RESBUF_TAG_EN
  logic [7:0]  out_tag;
`endif
  logic        almost_full;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [3:0]  count;

  int n_chk = 0;
  int n_err = 0;

  adder_result_buffer #(
    .DATA_WIDTH (32),
    .DEPTH      (8),
    .AF_THRESH  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sum      (in_sum),
    .in_carry    (in_carry),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carry   (out_carry),
`ifdef ADDER_RESBUF_TAG_EN
    .out_tag     (out_tag),
`endif
    .almost_full (almost_full),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [32:0] q[$];
  logic [32:0] held;
  logic        stall_prev;
  int          sent, recv, exp_tag;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = 1'b0; out_ready = 1'b0;

    // 1: reset with in_valid held high
    in_valid = 1'b1; in_sum = 32'hDEAD_BEEF;
    step(); step(); step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ovf",   64'(overflow), 64'd0);
    check("rst_drop",  64'(drop_cnt), 64'd0);
    check("rst_af",    64'(almost_full), 64'd0);

    // 2: single pass, one cycle latency
    out_ready = 1'b1; in_valid = 1'b1; in_sum = 32'h0000_0005; in_carry = 1'b0;
    step();
    in_valid = 1'b0;
    check("sp_valid", 64'(out_valid), 64'd1);
    check("sp_sum",   64'(out_sum), 64'd5);
    check("sp_carry", 64'(out_carry), 64'd0);
    check("sp_count", 64'(count), 64'd1);
    step();
    check("sp_valid_low", 64'(out_valid), 64'd0);
    check("sp_count0",    64'(count), 64'd0);

    // 3: fill with stalled consumer, then one drop, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sum = 32'(100 + i); in_carry = i[0];
      step();
      check("fill_count", 64'(count), 64'(i + 1));
      check("fill_af", 64'(almost_full), (i + 1 >= 6) ? 64'd1 : 64'd0);
    end
    check("fill_ovf0", 64'(overflow), 64'd0);
    in_sum = 32'd999;
    step();
    in_valid = 1'b0;
    check("ovf_set",   64'(overflow), 64'd1);
    check("ovf_drop",  64'(drop_cnt), 64'd1);
    check("ovf_count", 64'(count), 64'd8);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_sum",   64'(out_sum), 64'(100 + i));
      check("drain_carry", 64'(out_carry), 64'(i % 2));
      step();
    end
    check("drain_count", 64'(count), 64'd0);
    check("drain_valid0", 64'(out_valid), 64'd0);
    check("drain_af0", 64'(almost_full), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // 4: full with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sum = 32'(200 + i); in_carry = 1'b0;
      step();
    end
    check("fp_full", 64'(count), 64'd8);
    in_sum = 32'd300; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("fp_count", 64'(count), 64'd8);
    check("fp_drop",  64'(drop_cnt), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check("fp_order", 64'(out_sum), (i < 7) ? 64'(201 + i) : 64'd300);
      step();
    end
    check("fp_empty", 64'(count), 64'd0);

    // 5: random backpressure, scoreboard model
    sent = 0; recv = 0; stall_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 3000 && recv < 100; cyc++) begin
      check("bp_valid", 64'(out_valid), (q.size() != 0) ? 64'd1 : 64'd0);
      if (q.size() != 0) check("bp_head", 64'({out_carry, out_sum}), 64'(q[0]));
      if (stall_prev) check("bp_stable", 64'({out_carry, out_sum}), 64'(held));
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 100) && (q.size() < 8) && ($urandom_range(0, 3) != 0);
      in_carry  = (sent % 2) == 1;
      in_sum    = in_carry ? 32'hFFFF_FFFF : 32'(sent);
      stall_prev = (q.size() != 0) && !out_ready;
      held = {out_carry, out_sum};
      step();
      if ((q.size() != 0) && out_ready) begin
        void'(q.pop_front());
        recv++;
      end
      if (in_valid) begin
        q.push_back({in_carry, in_sum});
        sent++;
      end
    end
    in_valid = 1'b0;
    check("bp_recv", 64'(recv), 64'd100);
    check("bp_drop", 64'(drop_cnt), 64'd1);

`ifdef ADDER_RESBUF_TAG_EN
    // 6: tag sequence across wrap with three forced drops
    do_reset();
    check("tag_rst_drop", 64'(drop_cnt), 64'd0);
    out_ready = 1'b0; sent = 0;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_sum = 32'(i); in_carry = 1'b0;
      step();
      if (i < 8) sent++;
    end
    check("tag_drop3", 64'(drop_cnt), 64'd3);
    out_ready = 1'b1; exp_tag = 0; recv = 0;
    for (int cyc = 0; cyc < 2000 && recv < 300; cyc++) begin
      in_valid = (sent < 300);
      in_sum = 32'(sent);
      if (out_valid) begin
        check("tag_seq", 64'(out_tag), 64'(8'(exp_tag)));
        exp_tag++;
        recv++;
      end
      step();
      if (in_valid) sent++;
    end
    in_valid = 1'b0;
    check("tag_recv", 64'(recv), 64'd300);
    check("tag_drop_final", 64'(drop_cnt), 64'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
